// File: rtl/mult_div_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU opcodes,
// multiply/divide operation select and FSM state encodings.
package mult_div_sequencer_pkg;

    // ALU opcodes understood by the shared execute-stage ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;

    // Operation select on op_i
    localparam logic MD_MULTU = 1'b0;
    localparam logic MD_DIVU  = 1'b1;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer. Borrows the shared ALU for 32 radix-2
// iterations (ADD for shift-add multiply, SUB for restoring divide) and
// holds the architectural HI/LO registers.
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              alu_sel_o,
    output logic [3:0]        alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    md_state_e         state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic [DATA_W-1:0] alu_a_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [3:0]        alu_op_s;
    logic              mul_c_s;
    logic              div_ge_s;

    // Next-state, iteration datapath and ALU request
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        alu_op_s = ALU_ADD;
        alu_a_s  = {DATA_W{1'b0}};
        alu_b_s  = {DATA_W{1'b0}};
        mul_c_s  = 1'b0;
        div_ge_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    // Fresh operands; HI/LO keep their old value until commit
                    acc_d   = {DATA_W{1'b0}};
                    q_d     = rs_data_i;
                    m_d     = rt_data_i;
                    cnt_d   = {CNT_W{1'b0}};
                    op_d    = op_i;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (op_q == MD_MULTU) begin
                    // Add multiplicand when the current multiplier bit is set,
                    // then shift {carry, sum, q} right by one
                    alu_op_s = ALU_ADD;
                    alu_a_s  = acc_q;
                    alu_b_s  = q_q[0] ? m_q : {DATA_W{1'b0}};
                    mul_c_s  = (alu_result_i < acc_q);
                    acc_d    = {mul_c_s, alu_result_i[DATA_W-1:1]};
                    q_d      = {alu_result_i[0], q_q[DATA_W-1:1]};
                end else begin
                    // Shift remainder left, trial-subtract divisor; the
                    // bit shifted out of acc is the 33rd bit of the trial
                    alu_op_s = ALU_SUB;
                    alu_a_s  = {acc_q[DATA_W-2:0], q_q[DATA_W-1]};
                    alu_b_s  = m_q;
                    div_ge_s = acc_q[DATA_W-1] | (alu_a_s >= m_q);
                    acc_d    = div_ge_s ? alu_result_i : alu_a_s;
                    q_d      = {q_q[DATA_W-2:0], div_ge_s};
                end
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_ITER) begin
                    hi_d    = acc_d;
                    lo_d    = q_d;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_q   <= {DATA_W{1'b0}};
            q_q     <= {DATA_W{1'b0}};
            m_q     <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= MD_MULTU;
            hi_q    <= {DATA_W{1'b0}};
            lo_q    <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o    = (state_q == ST_CALC);
    assign done_o    = (state_q == ST_DONE);
    assign alu_sel_o = busy_o;
    assign alu_op_o  = alu_op_s;
    assign alu_a_o   = alu_a_s;
    assign alu_b_o   = alu_b_s;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed self-checking bench for mult_div_sequencer with a behavioural
// model of the shared ALU on the alu_* interface.
module tb_mult_div_sequencer;
    import mult_div_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic        op_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        alu_sel_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i;

    int          n_checks;
    int          n_errors;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    mult_div_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .op_i         (op_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .alu_sel_o    (alu_sel_o),
        .alu_op_o     (alu_op_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i)
    );

    // Shared execute-stage ALU model
    always_comb begin
        alu_result_i = 32'h0000_0000;
        case (alu_op_o)
            ALU_AND: alu_result_i = alu_a_o & alu_b_o;
            ALU_OR:  alu_result_i = alu_a_o | alu_b_o;
            ALU_XOR: alu_result_i = alu_a_o ^ alu_b_o;
            ALU_ADD: alu_result_i = alu_a_o + alu_b_o;
            ALU_SUB: alu_result_i = alu_a_o - alu_b_o;
            ALU_SLT: alu_result_i = {31'd0, ($signed(alu_a_o) < $signed(alu_b_o))};
            ALU_SLL: alu_result_i = alu_b_o << alu_a_o[4:0];
            default: alu_result_i = 32'h0000_0000;
        endcase
    end

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one operation. in_done: caller sits at the negedge of a DONE
    // cycle and the new start is taken there. mid: pulse start with junk
    // operands in the middle of CALC.
    task automatic run_op(input string tag, input logic op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit in_done, input bit mid);
        int busy_cnt;
        int done_cyc;
        if (in_done) check({tag, " done_at_restart"}, {63'd0, done_o}, 64'd1);
        else @(negedge clk);
        start_i   = 1'b1;
        op_i      = op;
        rs_data_i = a;
        rt_data_i = b;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        rs_data_i = 32'hDEAD_BEEF;
        rt_data_i = 32'h0000_0003;
        busy_cnt  = 0;
        done_cyc  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (c == 1) begin
                check({tag, " alu_sel"}, {63'd0, alu_sel_o}, 64'd1);
                check({tag, " alu_op"}, {60'd0, alu_op_o}, {60'd0, (op ? ALU_SUB : ALU_ADD)});
            end
            if (c == 16) begin
                check({tag, " hi_hold"}, {32'd0, hi_o}, {32'd0, prev_hi});
                check({tag, " lo_hold"}, {32'd0, lo_o}, {32'd0, prev_lo});
            end
            if (mid && c == 5) begin
                start_i   = 1'b1;
                op_i      = ~op;
                rs_data_i = 32'h0000_0005;
                rt_data_i = 32'h0000_0005;
            end else if (mid && c == 6) begin
                start_i = 1'b0;
            end
            if (done_o) begin
                done_cyc = c;
                break;
            end
        end
        check({tag, " latency"}, 64'(done_cyc), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({tag, " hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
        check({tag, " alu_idle"}, {31'd0, alu_sel_o, alu_a_o}, 64'd0);
        check({tag, " alu_b_idle"}, {28'd0, alu_op_o, alu_b_o}, {28'd0, ALU_ADD, 32'd0});
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    // Directed test sequence
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        prev_hi   = 32'd0;
        prev_lo   = 32'd0;
        reset     = 1'b0;
        start_i   = 1'b0;
        op_i      = MD_MULTU;
        rs_data_i = 32'd0;
        rt_data_i = 32'd0;
        repeat (2) @(negedge clk);
        check("rst busy_done", {62'd0, busy_o, done_o}, 64'd0);
        check("rst hilo", {hi_o, lo_o}, 64'd0);
        check("rst alu", {27'd0, alu_sel_o, alu_op_o, alu_a_o}, {27'd0, 1'b0, ALU_ADD, 32'd0});
        reset = 1'b1;

        run_op("mul7x6",  MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);
        run_op("mulmax",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("div100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        run_op("div8000_3", MD_DIVU, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA, 1'b0, 1'b0);
        run_op("div_by0", MD_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mid_start", MD_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 1'b1);
        run_op("b2b", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b1, 1'b0);

        // Abort an operation with reset at iteration 10
        @(negedge clk);
        start_i   = 1'b1;
        op_i      = MD_MULTU;
        rs_data_i = 32'd9;
        rt_data_i = 32'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_abort busy", {63'd0, busy_o}, 64'd1);
        reset = 1'b0;
        #1;
        check("abort busy_done", {62'd0, busy_o, done_o}, 64'd0);
        check("abort hilo", {hi_o, lo_o}, 64'd0);
        check("abort alu_sel", {63'd0, alu_sel_o}, 64'd0);
        @(negedge clk);
        reset   = 1'b1;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        run_op("post_rst", MD_MULTU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("final idle", {62'd0, busy_o, done_o}, 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
